// File: rtl/uart_tx_tick.sv
// Tick-paced serial transmitter: accepts a word over valid/ready and shifts it out
// LSB-first as start, data, optional parity and stop bits, one bit per baud tick.
module uart_tx_tick #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbg_state
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_tick: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_tick: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_tick: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int            CW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    // IDLE is encoded as 0 so dbg_state reads 0 whenever the line is free.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_PAR   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cap_par;

    // Parity bit is fixed at capture time from the whole word.
    assign cap_par = (PARITY == 2) ? ~^in_data : ^in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Handshake: a word moves when in_valid and in_ready are both high at a rising
    // edge; in_ready is high only in IDLE, and in_data/in_valid are ignored otherwise.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && ready_q) begin
                    state_d    = S_ARM;
                    shift_d    = in_data;
                    par_d      = cap_par;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_ARM: begin
                if (tick) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign in_ready  = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Bench for uart_tx_tick: three configurations (no parity, even, odd with two stops)
// fed from a 4-clock baud tick and checked interval by interval against a frame model.
module tb_uart_tx_tick;

    localparam int ND = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic [7:0]       in_data_r [ND];
    logic [ND-1:0]    in_valid_r;
    wire  [ND-1:0]    in_ready_w;
    wire  [ND-1:0]    tx_w;
    wire  [ND-1:0]    busy_w;
    wire  [ND-1:0]    done_w;
    wire  [2:0]       dbg_w [ND];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Baud strobe: one-cycle pulse every 4 clocks, changed on the falling edge.
    initial begin : tick_gen
        int ph;
        ph   = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (ph == 3);
            ph   = (ph + 1) % 4;
        end
    end

    uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst(rst), .tick(tick), .in_data(in_data_r[0]), .in_valid(in_valid_r[0]),
        .in_ready(in_ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .dbg_state(dbg_w[0]));

    uart_tx_tick #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d1 (
        .clk(clk), .rst(rst), .tick(tick), .in_data(in_data_r[1]), .in_valid(in_valid_r[1]),
        .in_ready(in_ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .dbg_state(dbg_w[1]));

    uart_tx_tick #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_d2 (
        .clk(clk), .rst(rst), .tick(tick), .in_data(in_data_r[2]), .in_valid(in_valid_r[2]),
        .in_ready(in_ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .dbg_state(dbg_w[2]));

    function automatic int parity_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
    endfunction

    function automatic int stops_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // All configurations must sit idle for n cycles.
    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                chk("idle_tx", tx_w[d], 1'b1);
                chk("idle_ready", in_ready_w[d], 1'b1);
                chk("idle_busy", busy_w[d], 1'b0);
                chk("idle_done", done_w[d], 1'b0);
                chk("idle_state", dbg_w[d] == 3'd0, 1'b1);
                if (!in_valid_r[d]) in_data_r[d] = 8'($urandom);
            end
        end
    endtask

    // Offer word w to config d at the next edge and follow the frame tick by tick.
    // abort_at >= 0 pulses rst once the abort_at-th frame bit is on the line.
    task automatic xfer(input int d, input logic [7:0] w, input int abort_at, input bit keep);
        logic [0:0] exp_q[$];
        int         k;
        int         cyc;
        int         nb;
        int         pv;
        logic       t;
        logic       exp_tx;
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
        pv = parity_of(d);
        if (pv == 1) exp_q.push_back(1'($countones(w) % 2));
        if (pv == 2) exp_q.push_back(1'(($countones(w) + 1) % 2));
        for (int s = 0; s < stops_of(d); s++) exp_q.push_back(1'b1);
        nb = exp_q.size();

        chk("pre_ready", in_ready_w[d], 1'b1);
        in_data_r[d]  = w;
        in_valid_r[d] = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_ready", in_ready_w[d], 1'b0);
        chk("accept_busy", busy_w[d], 1'b1);
        chk("accept_done", done_w[d], 1'b0);
        chk("accept_tx", tx_w[d], 1'b1);
        in_data_r[d] = 8'($urandom);

        k   = -1;
        cyc = 0;
        while (k < nb) begin
            @(posedge clk);
            t = tick;
            #1;
            cyc++;
            if (t) k++;
            if (k < nb) begin
                exp_tx = (k < 0) ? 1'b1 : exp_q[k];
                chk("frame_tx", tx_w[d], exp_tx);
                chk("frame_done", done_w[d], 1'b0);
                chk("frame_busy", busy_w[d], 1'b1);
                chk("frame_ready", in_ready_w[d], 1'b0);
                chk("frame_state", dbg_w[d] != 3'd0, 1'b1);
                in_data_r[d] = 8'($urandom);
            end else begin
                chk("end_tx", tx_w[d], 1'b1);
                chk("end_done", done_w[d], 1'b1);
                chk("end_busy", busy_w[d], 1'b0);
                chk("end_ready", in_ready_w[d], 1'b1);
            end
            if (k == abort_at) begin
                in_valid_r[d] = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("abort_tx", tx_w[d], 1'b1);
                chk("abort_busy", busy_w[d], 1'b0);
                chk("abort_ready", in_ready_w[d], 1'b1);
                chk("abort_done", done_w[d], 1'b0);
                return;
            end
            if (cyc > 4 * nb + 12) begin
                checks++;
                failures++;
                $error("FAIL frame_timeout cfg=%0d observed_bits=%0d expected_bits=%0d", d, k, nb);
                break;
            end
        end
        if (!keep) in_valid_r[d] = 1'b0;
    endtask

    // Sit just before an edge on which tick is sampled high.
    task automatic align_to_tick();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!tick && guard < 16);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : main
        rst        = 1'b1;
        in_valid_r = '0;
        for (int d = 0; d < ND; d++) in_data_r[d] = 8'h00;

        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                chk("rst_tx", tx_w[d], 1'b1);
                chk("rst_ready", in_ready_w[d], 1'b1);
                chk("rst_busy", busy_w[d], 1'b0);
                chk("rst_done", done_w[d], 1'b0);
            end
        end
        rst = 1'b0;
        idle_check(20);

        // 0xA5 on each configuration (no parity, even, odd), plus 0x07 with even parity.
        xfer(0, 8'hA5, -1, 1'b0);
        idle_check(2);
        xfer(1, 8'hA5, -1, 1'b0);
        idle_check(1);
        xfer(2, 8'hA5, -1, 1'b0);
        idle_check(1);
        xfer(1, 8'h07, -1, 1'b0);
        idle_check(3);

        // in_valid held across two frames: second word taken the cycle ready returns.
        for (int d = 0; d < ND; d++) begin
            xfer(d, 8'h55, -1, 1'b1);
            xfer(d, 8'hAA, -1, 1'b0);
            idle_check(2);
        end

        // Transfer on the same edge as a tick: that tick must not start the frame.
        for (int d = 0; d < ND; d++) begin
            align_to_tick();
            xfer(d, 8'($urandom), -1, 1'b0);
            idle_check(1);
        end

        // Reset mid-frame, then a clean frame.
        xfer(0, 8'hFF, 4, 1'b0);
        idle_check(1);
        xfer(0, 8'h00, -1, 1'b0);
        idle_check(1);
        xfer(2, 8'h00, 2, 1'b0);
        idle_check(1);
        xfer(2, 8'($urandom), -1, 1'b0);
        idle_check(1);

        // Random words, configurations and gaps.
        for (int r = 0; r < 15; r++) begin
            int d;
            d = $urandom_range(0, ND - 1);
            idle_check($urandom_range(0, 6));
            xfer(d, 8'($urandom), -1, 1'b0);
        end
        idle_check(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
